snn_lif_core: RTL and testbench

Parametrised spiking-neural-network core: N_NEURONS leaky integrate-and-fire processing elements sharing one on-chip weight memory. Accepts sensor events over a valid/ready handshake and accumulates the addressed weight row into every neuron's membrane potential. Fires and resets neurons that cross threshold, applying leak on a timestep tick. Fired neuron indices are queued in an output FIFO read by the SoC bus side.

---
 rtl/snn_lif_core.sv | 189 ++++++++++++++++++
 tb/tb_snn_lif_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_lif_core.sv
// snn_lif_core: N_NEURONS leaky integrate-and-fire neurons sharing one weight memory.
// An accepted sensor event adds weight row [in_addr] into every membrane potential
// (saturating), then a scan fires neurons at or above THRESHOLD into an output FIFO.
// A tick requests one leak step: V <- V - (V >>> LEAK_SHIFT).
//
// Ports:
//   clock, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_addr sensor event handshake and address
//   tick                     timestep pulse requesting leak
//   wmem_we/waddr/wdata      weight write port, address = input*N_NEURONS + neuron
//   out_ren                  pop output FIFO
//   out_addr                 FIFO head (first-word fall-through), 0 while empty
//   out_empty/out_full       FIFO status
//   busy                     FSM not idle
module snn_lif_core #(
  parameter int unsigned N_NEURONS  = 16,
  parameter int unsigned N_INPUTS   = 16,
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned V_WIDTH    = 16,
  parameter int unsigned THRESHOLD  = 64,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned OUT_DEPTH  = 8
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [$clog2(N_INPUTS)-1:0]             in_addr,
  input  logic                                    tick,
  input  logic                                    wmem_we,
  input  logic [$clog2(N_INPUTS*N_NEURONS)-1:0]   wmem_waddr,
  input  logic signed [W_WIDTH-1:0]               wmem_wdata,
  input  logic                                    out_ren,
  output logic [$clog2(N_NEURONS)-1:0]            out_addr,
  output logic                                    out_empty,
  output logic                                    out_full,
  output logic                                    busy
);

  localparam int unsigned NW = $clog2(N_NEURONS);
  localparam int unsigned IW = $clog2(N_INPUTS);
  localparam int unsigned AW = $clog2(N_INPUTS * N_NEURONS);
  localparam int unsigned FW = $clog2(OUT_DEPTH);

  localparam logic [NW:0] CntOne      = 1;
  localparam logic [NW:0] CntAccLast  = N_NEURONS;
  localparam logic [NW:0] CntScanLast = N_NEURONS - 1;
  localparam logic signed [V_WIDTH-1:0] Thr = V_WIDTH'(THRESHOLD);
  localparam logic [V_WIDTH-1:0] VMax = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic [V_WIDTH-1:0] VMin = {1'b1, {(V_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StScan, StLeak} state_e;

  state_e                      r_state, w_state_nxt;
  logic [NW:0]                 r_cnt, w_cnt_nxt;
  logic [IW-1:0]               r_addr;
  logic                        r_tick_pend, w_tick_pend_nxt;
  logic                        w_load;
  logic signed [V_WIDTH-1:0]   r_v     [N_NEURONS];
  logic signed [V_WIDTH-1:0]   w_v_nxt [N_NEURONS];

  logic signed [W_WIDTH-1:0]   r_wmem  [N_INPUTS*N_NEURONS];
  logic signed [W_WIDTH-1:0]   r_rdata;
  logic [AW-1:0]               w_raddr;

  logic [NW-1:0]               r_fifo  [OUT_DEPTH];
  logic [FW:0]                 r_wptr, r_rptr;
  logic                        w_push, w_pop, w_full, w_empty;

  logic [NW-1:0]               w_acc_idx, w_scan_idx;
  logic signed [V_WIDTH-1:0]   w_acc_old;
  logic [V_WIDTH:0]            w_sum;
  logic [V_WIDTH-1:0]          w_sat;
  logic                        w_fire, w_scan_adv;

  // Weight memory: read issued in ACCUM cycle k targets neuron k of the latched row.
  assign w_raddr = {r_addr, r_cnt[NW-1:0]};

  always_ff @(posedge clock) begin
    if (wmem_we) r_wmem[wmem_waddr] <= wmem_wdata;
    r_rdata <= r_wmem[w_raddr];
  end

  // Read data arriving in ACCUM cycle k belongs to neuron k-1 (wraps to N-1 when k == N).
  assign w_acc_idx = r_cnt[NW-1:0] - NW'(1);
  assign w_acc_old = r_v[w_acc_idx];
  assign w_sum     = {w_acc_old[V_WIDTH-1], w_acc_old}
                   + {{(V_WIDTH+1-W_WIDTH){r_rdata[W_WIDTH-1]}}, r_rdata};

  // Overflow when the two top bits of the widened sum disagree; clamp by true sign.
  always_comb begin
    w_sat = w_sum[V_WIDTH-1:0];
    if (w_sum[V_WIDTH] != w_sum[V_WIDTH-1]) w_sat = w_sum[V_WIDTH] ? VMin : VMax;
  end

  assign w_scan_idx = r_cnt[NW-1:0];
  assign w_fire     = (r_v[w_scan_idx] >= Thr);
  assign w_push     = (r_state == StScan) && w_fire && !w_full;
  // A firing neuron holds the scan until the FIFO has room.
  assign w_scan_adv = (r_state == StScan) && (!w_fire || !w_full);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tick_pend_nxt = r_tick_pend | tick;
    w_load          = 1'b0;
    for (int j = 0; j < int'(N_NEURONS); j++) w_v_nxt[j] = r_v[j];
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (r_tick_pend) begin
          w_state_nxt = StLeak;
        end else if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = StAccum;
        end
      end
      StAccum: begin
        if (r_cnt != '0) w_v_nxt[w_acc_idx] = w_sat;
        if (r_cnt == CntAccLast) begin
          w_state_nxt = StScan;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StScan: begin
        if (w_scan_adv) begin
          if (w_fire) w_v_nxt[w_scan_idx] = '0;
          if (r_cnt == CntScanLast) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CntOne;
          end
        end
      end
      StLeak: begin
        for (int j = 0; j < int'(N_NEURONS); j++) w_v_nxt[j] = r_v[j] - (r_v[j] >>> LEAK_SHIFT);
        // Any tick arriving now merges into this leak.
        w_tick_pend_nxt = 1'b0;
        w_state_nxt     = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_tick_pend <= 1'b0;
      for (int j = 0; j < int'(N_NEURONS); j++) r_v[j] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tick_pend <= w_tick_pend_nxt;
      if (w_load) r_addr <= in_addr;
      for (int j = 0; j < int'(N_NEURONS); j++) r_v[j] <= w_v_nxt[j];
    end
  end

  // Output FIFO, extra pointer bit separates full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FW] != r_rptr[FW]) && (r_wptr[FW-1:0] == r_rptr[FW-1:0]);
  assign w_pop   = out_ren && !w_empty;

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wptr[FW-1:0]] <= w_scan_idx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  assign out_addr  = w_empty ? '0 : r_fifo[r_rptr[FW-1:0]];
  assign out_empty = w_empty;
  assign out_full  = w_full;
  assign busy      = (r_state != StIdle);
  assign in_ready  = reset_n && (r_state == StIdle) && !r_tick_pend;

endmodule

// File: tb/tb_snn_lif_core.sv
// Self-checking bench for snn_lif_core: directed table, FIFO stall, merged ticks,
// narrow-V saturation (second instance), random events against a behavioural model,
// and reset mid-scan.
module tb_snn_lif_core;

  localparam int N  = 16;
  localparam int NI = 16;
  localparam int TH = 64;
  localparam int LS = 4;
  localparam int VW = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0, in_ready;
  logic [3:0]        in_addr = '0;
  logic              tick = 1'b0;
  logic              wmem_we = 1'b0;
  logic [7:0]        wmem_waddr = '0;
  logic signed [7:0] wmem_wdata = '0;
  logic              out_ren = 1'b0;
  logic [3:0]        out_addr;
  logic              out_empty, out_full, busy;

  logic              s_valid = 1'b0, s_ready;
  logic [3:0]        s_addr = '0;
  logic              s_tick = 1'b0;
  logic              s_we = 1'b0;
  logic [7:0]        s_waddr = '0;
  logic signed [7:0] s_wdata = '0;
  logic              s_ren = 1'b0;
  logic [3:0]        s_oaddr;
  logic              s_empty, s_full, s_busy;

  always #5 clock = ~clock;

  snn_lif_core dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .tick(tick), .wmem_we(wmem_we), .wmem_waddr(wmem_waddr),
    .wmem_wdata(wmem_wdata), .out_ren(out_ren), .out_addr(out_addr),
    .out_empty(out_empty), .out_full(out_full), .busy(busy)
  );

  snn_lif_core #(.V_WIDTH(9)) dut_s (
    .clock(clock), .reset_n(reset_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_addr(s_addr), .tick(s_tick), .wmem_we(s_we), .wmem_waddr(s_waddr),
    .wmem_wdata(s_wdata), .out_ren(s_ren), .out_addr(s_oaddr),
    .out_empty(s_empty), .out_full(s_full), .busy(s_busy)
  );

  int n_cmp = 0, n_fail = 0;
  int mv[N];
  int wt[NI*N];
  int expq[$];
  bit drain = 1'b0;
  int n_pops = 0;

  typedef struct {
    int wa; int wn; int wv; bit wr; bit tk; int ev; int chk_n; int exp_v; int exp_spk;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int x, input int vw);
    int lo, hi;
    lo = -(1 << (vw - 1));
    hi = (1 << (vw - 1)) - 1;
    return (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  // Leak subtracts floor(V / 2^LS).
  function automatic int leak_of(input int x);
    int d, q;
    d = 1 << LS;
    q = (x >= 0) ? x / d : -((-x + d - 1) / d);
    return x - q;
  endfunction

  task automatic model_event(input int a);
    for (int k = 0; k < N; k++) mv[k] = clampv(mv[k] + wt[a*N+k], VW);
    for (int j = 0; j < N; j++) if (mv[j] >= TH) begin expq.push_back(j); mv[j] = 0; end
  endtask

  task automatic model_leak();
    for (int j = 0; j < N; j++) mv[j] = leak_of(mv[j]);
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) mv[j] = 0;
    expq.delete();
  endtask

  task automatic step();
    if (drain && !out_empty) begin
      out_ren = 1'b1;
      n_pops++;
      if (expq.size() == 0) check("fifo_extra_pop", int'(out_addr), -1);
      else check("fifo_head", int'(out_addr), expq.pop_front());
    end
    @(posedge clock);
    #1;
    out_ren = 1'b0; in_valid = 1'b0; tick = 1'b0; wmem_we = 1'b0; s_valid = 1'b0; s_we = 1'b0;
  endtask

  task automatic wr_w(input int a, input int n, input int val);
    wmem_we = 1'b1; wmem_waddr = 8'(a*N + n); wmem_wdata = 8'(val);
    wt[a*N+n] = val;
    step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (!in_ready) check("ready_timeout", int'(in_ready), 1);
  endtask

  task automatic accept(input int a);
    wait_ready();
    in_valid = 1'b1; in_addr = 4'(a);
    step();
    model_event(a);
    check("busy_after_accept", int'(busy), 1);
    check("ready_low_after_accept", int'(in_ready), 0);
  endtask

  task automatic send_event(input int a, input int nt, output int lowcyc);
    accept(a);
    if (nt > 0) model_leak();
    lowcyc = 0;
    while (!in_ready && lowcyc < 300) begin
      if (lowcyc < nt) tick = 1'b1;
      step();
      lowcyc++;
    end
  endtask

  task automatic do_tick(output int lowcyc);
    tick = 1'b1;
    step();
    model_leak();
    lowcyc = 0;
    while (!in_ready && lowcyc < 20) begin step(); lowcyc++; end
  endtask

  task automatic check_v(input string tag);
    for (int j = 0; j < N; j++) check($sformatf("%s_v%0d", tag, j), int'(dut.r_v[j]), mv[j]);
  endtask

  task automatic s_event(input int a);
    int n = 0;
    while (!s_ready && n < 100) begin step(); n++; end
    s_valid = 1'b1; s_addr = 4'(a);
    step();
    n = 0;
    while (!s_ready && n < 100) begin step(); n++; end
    check("s_ready_return", int'(s_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, n;
    tbl[0] = '{1, 3, 40, 1'b1, 1'b0,  1, 3, 40, -1};
    tbl[1] = '{1, 3,  0, 1'b0, 1'b0,  1, 3,  0,  3};
    tbl[2] = '{4, 5, 40, 1'b1, 1'b0,  4, 5, 40, -1};
    tbl[3] = '{0, 0,  0, 1'b0, 1'b1, -1, 5, 38, -1};
    tbl[4] = '{6, 5, 26, 1'b1, 1'b0,  6, 5,  0,  5};
    model_reset();

    // Reset values while held in reset
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_empty", int'(out_empty), 1);
    check("rst_out_full", int'(out_full), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    step();
    check("rel_in_ready", int'(in_ready), 1);
    check_v("rel");

    for (int i = 0; i < NI*N; i++) wr_w(i / N, i % N, 0);

    // Directed table
    for (int r = 0; r < 5; r++) begin
      if (tbl[r].wr) wr_w(tbl[r].wa, tbl[r].wn, tbl[r].wv);
      if (tbl[r].tk) begin
        do_tick(lc);
        check($sformatf("row%0d_tick_low", r), lc, 2);
      end else begin
        send_event(tbl[r].ev, 0, lc);
        check($sformatf("row%0d_event_low", r), lc, 2*N + 1);
      end
      check($sformatf("row%0d_v", r), int'(dut.r_v[tbl[r].chk_n]), tbl[r].exp_v);
      if (tbl[r].exp_spk < 0) begin
        check($sformatf("row%0d_empty", r), int'(out_empty), 1);
      end else begin
        check($sformatf("row%0d_nonempty", r), int'(out_empty), 0);
        check($sformatf("row%0d_spike", r), int'(out_addr), tbl[r].exp_spk);
        out_ren = 1'b1;
        if (expq.size() > 0) void'(expq.pop_front());
        step();
        check($sformatf("row%0d_empty_after_pop", r), int'(out_empty), 1);
      end
    end
    check_v("table");

    // FIFO fills, scan stalls at neuron 8, then drain
    for (int k = 0; k < N; k++) wr_w(2, k, 70);
    accept(2);
    n = 0;
    while (!out_full && n < 100) begin step(); n++; end
    check("full_reached", int'(out_full), 1);
    for (int i = 0; i < 4; i++) step();
    check("stall_busy", int'(busy), 1);
    check("stall_full", int'(out_full), 1);
    check("stall_head", int'(out_addr), 0);
    check("stall_v8_kept", int'(dut.r_v[8]), 70);
    check("stall_v7_cleared", int'(dut.r_v[7]), 0);
    check("stall_v9_kept", int'(dut.r_v[9]), 70);
    drain = 1'b1;
    n_pops = 0;
    n = 0;
    while ((!in_ready || !out_empty) && n < 200) begin step(); n++; end
    check("drain_pops", n_pops, 16);
    check("drain_empty", int'(out_empty), 1);
    check_v("drain");

    // Three ticks during ACCUM merge into one leak
    wr_w(7, 0, 50);
    wr_w(7, 1, -100);
    send_event(7, 3, lc);
    check("merged_tick_low", lc, 2*N + 3);
    check("merged_v0", int'(dut.r_v[0]), 47);
    check("merged_v1", int'(dut.r_v[1]), -93);
    check_v("merged");

    // Narrow V_WIDTH instance: clamping instead of wrap
    for (int k = 0; k < N; k++) begin
      s_we = 1'b1; s_waddr = 8'(k); s_wdata = -8'sd128; step();
      s_we = 1'b1; s_waddr = 8'(N + k); s_wdata = 8'sd100; step();
    end
    for (int i = 0; i < 3; i++) s_event(0);
    check("narrow_clamp_v0", int'(dut_s.r_v[0]), clampv(-384, 9));
    check("narrow_clamp_v15", int'(dut_s.r_v[15]), -256);
    s_event(1);
    check("narrow_after_pos_v0", int'(dut_s.r_v[0]), -156);
    check("narrow_no_spike", int'(s_empty), 1);
    check("narrow_not_full", int'(s_full), 0);
    check("narrow_idle", int'(s_busy), 0);
    check("narrow_head", int'(s_oaddr), 0);

    // Random events against the model
    for (int i = 0; i < NI*N; i++) wr_w(i / N, i % N, int'($urandom_range(0, 255)) - 128);
    for (int it = 0; it < 20; it++) begin
      int a, nt;
      a  = int'($urandom_range(0, NI - 1));
      nt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_event(a, nt, lc);
      check($sformatf("rand%0d_low", it), lc, 2*N + 1 + ((nt > 0) ? 2 : 0));
      if ($urandom_range(0, 4) == 0) begin
        do_tick(lc);
        check($sformatf("rand%0d_tick_low", it), lc, 2);
      end
      check_v($sformatf("rand%0d", it));
    end
    n = 0;
    while (!out_empty && n < 50) begin step(); n++; end
    check("rand_final_empty", int'(out_empty), 1);
    drain = 1'b0;

    // Reset during SCAN with three FIFO entries
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_reset();
    step();
    for (int k = 0; k < N; k++) wr_w(8, k, 100);
    accept(8);
    n = 0;
    while (out_empty && n < 100) begin step(); n++; end
    step(); step();
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_head", int'(out_addr), 0);
    check("pre_reset_cnt", int'(dut.r_wptr - dut.r_rptr), 3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_empty", int'(out_empty), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_full", int'(out_full), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("postrst_in_ready", int'(in_ready), 1);
    check_v("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
